// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction sequencer.
package instr_pkg;

    // Motion direction encoding carried in instr[1:0].
    typedef enum logic [1:0] {
        FWD   = 2'b00,
        REV   = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    // One stored instruction: torque in [3:2], direction in [1:0].
    typedef struct packed {
        logic [1:0] torque;
        dir_t       dir;
    } instr_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } seq_state_t;

    // One second at 50 MHz.
    localparam int unsigned STEP_CYCLES_DEFAULT = 32'd50_000_000;

endpackage

// File: rtl/instr_sequencer_step_timer.sv
// Step timer: loads the hold length and counts down while enabled. The expire
// pulse fires on the last enabled cycle, so a hold lasts exactly STEP_CYCLES.
module step_timer
    import instr_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT,
    parameter int unsigned W           = $clog2(STEP_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LOAD_VAL = W'(STEP_CYCLES);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] cnt_r;

    // Down-counter: reload on load, decrement while enabled and non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (en && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == ONE);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: records up to DEPTH motor instructions and replays
// them, holding each one on the motor outputs for STEP_CYCLES cycles.
module instr_sequencer
    import instr_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
    input  logic                       CLOCK50,
    input  logic                       reset_n,
    input  logic [3:0]                 instr_in,
    input  logic                       save,
    input  logic                       execute,
    input  logic                       delete,
    output logic [1:0]                 dir_out,
    output logic [1:0]                 torque_out,
    output logic                       motor_en,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       full,
    output logic                       empty,
    output logic                       done
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    seq_state_t    state_r, state_next_s;
    logic [CW-1:0] count_r;
    logic [PW-1:0] ptr_r;
    instr_t        mem_r [DEPTH];
    logic          motor_en_r, done_r;
    logic [1:0]    dir_r, torque_r;

    logic          empty_s, full_s, last_s;
    logic          wr_en_s, cnt_inc_s, cnt_dec_s;
    logic          timer_load_s, timer_en_s, timer_expire_s;

    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == CW'(DEPTH));
    assign last_s     = (({1'b0, ptr_r} + CW'(1)) >= count_r);
    assign timer_en_s = (state_r == HOLD);

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk    (CLOCK50),
        .rst_n  (reset_n),
        .load   (timer_load_s),
        .en     (timer_en_s),
        .expire (timer_expire_s)
    );

    // Next-state and program-edit decisions; edits only happen while idle and
    // delete wins over a coincident save.
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        cnt_inc_s    = 1'b0;
        cnt_dec_s    = 1'b0;
        timer_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (delete) begin
                    cnt_dec_s = !empty_s;
                end else if (save && !full_s) begin
                    wr_en_s   = 1'b1;
                    cnt_inc_s = 1'b1;
                end else begin
                    cnt_dec_s = 1'b0;
                end
                // Do not start a run whose only instruction is being deleted.
                if (execute && !empty_s && !(cnt_dec_s && (count_r == CW'(1)))) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                timer_load_s = 1'b1;
                state_next_s = HOLD;
            end
            HOLD: begin
                if (timer_expire_s) begin
                    state_next_s = last_s ? IDLE : FETCH;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control registers and registered motor/status outputs.
    always_ff @(posedge CLOCK50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            count_r    <= {CW{1'b0}};
            ptr_r      <= {PW{1'b0}};
            motor_en_r <= 1'b0;
            dir_r      <= 2'b00;
            torque_r   <= 2'b00;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (cnt_dec_s) begin
                count_r <= count_r - CW'(1);
            end else if (cnt_inc_s) begin
                count_r <= count_r + CW'(1);
            end else begin
                count_r <= count_r;
            end
            if ((state_r == HOLD) && timer_expire_s) begin
                ptr_r <= last_s ? {PW{1'b0}} : (ptr_r + PW'(1));
            end else begin
                ptr_r <= ptr_r;
            end
            done_r <= (state_r == HOLD) && timer_expire_s && last_s;
            if (state_r == FETCH) begin
                motor_en_r <= 1'b1;
                dir_r      <= mem_r[ptr_r].dir;
                torque_r   <= mem_r[ptr_r].torque;
            end else if ((state_r == HOLD) && (state_next_s == HOLD)) begin
                motor_en_r <= motor_en_r;
                dir_r      <= dir_r;
                torque_r   <= torque_r;
            end else begin
                motor_en_r <= 1'b0;
                dir_r      <= 2'b00;
                torque_r   <= 2'b00;
            end
        end
    end

    // Program storage; deliberately not reset, stale entries sit beyond count.
    always_ff @(posedge CLOCK50) begin
        if (wr_en_s) begin
            mem_r[count_r[PW-1:0]] <= instr_t'(instr_in);
        end
    end

    assign motor_en   = motor_en_r;
    assign dir_out    = dir_r;
    assign torque_out = torque_r;
    assign done       = done_r;
    assign count      = count_r;
    assign busy       = (state_r != IDLE);
    assign full       = full_s;
    assign empty      = empty_s;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes a cycle-stamped
// expected output trace, a negedge monitor pops and compares every cycle.
module tb_instr_sequencer;

    localparam int DEPTH = 4;
    localparam int S     = 4;
    localparam int CW    = 3;

    logic          CLOCK50 = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    instr_in = 4'h0;
    logic          save = 1'b0, execute = 1'b0, delete = 1'b0;
    logic [1:0]    dir_out, torque_out;
    logic          motor_en, busy, full, empty, done;
    logic [CW-1:0] count;

    instr_sequencer #(.DEPTH(DEPTH), .STEP_CYCLES(S)) dut (
        .CLOCK50(CLOCK50), .reset_n(reset_n), .instr_in(instr_in),
        .save(save), .execute(execute), .delete(delete),
        .dir_out(dir_out), .torque_out(torque_out), .motor_en(motor_en),
        .count(count), .busy(busy), .full(full), .empty(empty), .done(done)
    );

    always #5 CLOCK50 = ~CLOCK50;

    int cyc = 0;
    always @(posedge CLOCK50) cyc <= cyc + 1;

    // Expected output vector {busy, done, motor_en, dir, torque} at a cycle.
    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] prog[$];
    int         busy_end = -1;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, want);
        end
    endfunction

    // Reference model: a program is a list; a run of n instructions takes
    // n*(S+1) busy cycles (1 fetch + S hold each), then one done cycle.
    function automatic void model_apply(bit s, bit d, bit e, logic [3:0] ins);
        int n;
        if (cyc <= busy_end) return;
        if (d) begin
            if (prog.size() > 0) void'(prog.pop_back());
        end else if (s && prog.size() < DEPTH) begin
            prog.push_back(ins);
        end
        if (e && prog.size() > 0) begin
            n = prog.size();
            for (int j = 0; j < n; j++) begin
                exp_q.push_back('{cyc + 1 + j * (S + 1), 7'b100_0000});
                for (int t = 0; t < S; t++)
                    exp_q.push_back('{cyc + 2 + j * (S + 1) + t,
                                      {3'b101, prog[j][1:0], prog[j][3:2]}});
            end
            exp_q.push_back('{cyc + 1 + n * (S + 1), 7'b010_0000});
            busy_end = cyc + n * (S + 1);
        end
    endfunction

    // Monitor: compare every cycle against the scheduled trace (idle if none).
    always @(negedge CLOCK50) begin
        logic [6:0] want;
        want = 7'b0;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("sb_stale", 32'(exp_q[0].cyc), 32'(cyc));
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) want = exp_q.pop_front().v;
        check("outputs", 32'({busy, done, motor_en, dir_out, torque_out}), 32'(want));
    end

    // Issue one input cycle (called at posedge+1), then check the count flags.
    task automatic do_op(input bit s, input bit d, input bit e, input logic [3:0] ins);
        instr_in = ins; save = s; delete = d; execute = e;
        model_apply(s, d, e, ins);
        @(posedge CLOCK50); #1;
        save = 1'b0; delete = 1'b0; execute = 1'b0;
        check("count", 32'(count), 32'(prog.size()));
        check("full",  32'(full),  32'(prog.size() == DEPTH));
        check("empty", 32'(empty), 32'(prog.size() == 0));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLOCK50); #1; end
    endtask

    task automatic wait_idle();
        while (cyc <= busy_end) begin @(posedge CLOCK50); #1; end
    endtask

    initial begin
        logic [3:0] r;
        int op;
        idle(3);
        reset_n = 1'b1;

        // Four saves of increasing torque, then a full run.
        do_op(1, 0, 0, 4'h0); do_op(1, 0, 0, 4'h4);
        do_op(1, 0, 0, 4'h8); do_op(1, 0, 0, 4'hC);
        do_op(0, 0, 1, 4'h0); wait_idle(); idle(2);

        // Fifth save ignored when full; run shows only the first four.
        do_op(1, 0, 0, 4'h7); do_op(0, 0, 1, 4'h0); wait_idle(); idle(1);
        repeat (4) do_op(0, 1, 0, 4'h0);
        do_op(0, 1, 0, 4'h0);

        // Delete removes the last save; save+delete performs only the delete.
        do_op(1, 0, 0, 4'hE); do_op(1, 0, 0, 4'h1); do_op(0, 1, 0, 4'h0);
        do_op(0, 0, 1, 4'h0); wait_idle(); idle(1);
        do_op(1, 1, 0, 4'h5);

        // Execute when empty; edits and execute during HOLD are ignored.
        do_op(0, 0, 1, 4'h0); idle(2);
        do_op(1, 0, 0, 4'h3); do_op(1, 0, 0, 4'h6); do_op(1, 0, 0, 4'h9);
        do_op(0, 0, 1, 4'h0); idle(3);
        do_op(1, 0, 0, 4'hF); do_op(0, 1, 0, 4'h0); do_op(0, 0, 1, 4'h0);
        wait_idle();

        // Replay of the retained program.
        do_op(0, 0, 1, 4'h0); wait_idle(); idle(1);

        // Reset in the middle of a hold.
        do_op(0, 0, 1, 4'h0); idle(3);
        check("pre_rst_busy", 32'(busy), 32'(cyc <= busy_end));
        reset_n = 1'b0;
        exp_q.delete(); prog.delete(); busy_end = -1;
        #1;
        check("rst_motor", 32'({motor_en, dir_out, torque_out}), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_busy",  32'({busy, done}), 32'(0));
        @(posedge CLOCK50); #1;
        reset_n = 1'b1;
        do_op(0, 0, 1, 4'h0); idle(3);

        // Randomized program editing and runs, including inputs while busy.
        repeat (80) begin
            op = $urandom_range(0, 9);
            r  = 4'($urandom_range(0, 15));
            if (op <= 3)      do_op(1, 0, 0, r);
            else if (op <= 5) do_op(0, 1, 0, r);
            else if (op == 6) do_op(1, 1, 0, r);
            else if (op <= 8) do_op(0, 0, 1, r);
            else              idle(1);
        end
        wait_idle(); idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
